ads127l01_capture_ctrl: RTL and testbench
=========================================

ADS127L01_CAPTURE_CTRL -- requirements
Module: ads127l01_capture_ctrl

Interface
REQ-001 SHALL have parameter PWRUP_CYC, default 1024: clk cycles with pd high before start asserts.
REQ-002 SHALL have parameter DISCARD, default 2: samples dropped after start for filter settling.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of 2): output buffer depth.
REQ-004 SHALL have port clk, input, 1: system clock.
REQ-005 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-006 SHALL have port cmd_start, input, 1: one-cycle pulse that begins a session.
REQ-007 SHALL have port cmd_stop, input, 1: one-cycle pulse that aborts a session.
REQ-008 SHALL have port num_samples, input, 16: session length; 0 means continuous.
REQ-009 SHALL have port smp_data, input, 24: sample word from the serial receiver.
REQ-010 SHALL have port smp_valid, input, 1: one-cycle clk-domain strobe, one per sample.
REQ-011 SHALL have port adc_pd, output, 1: ADC power-down pin, active-low.
REQ-012 SHALL have port adc_start, output, 1: ADC START pin.
REQ-013 SHALL have port rx_en, output, 1: receiver enable.
REQ-014 SHALL have port m_data, output, 24: buffered sample.
REQ-015 SHALL have port m_valid, output, 1: m_data is valid.
REQ-016 SHALL have port m_ready, input, 1: consumer accepts the sample.
REQ-017 SHALL have port m_last, output, 1: marks the final sample of a finite session.
REQ-018 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-019 SHALL have port overrun, output, 1: sticky sample-dropped flag.

Function
REQ-020 FSM states SHALL be IDLE, PWRUP, SETTLE, CAPTURE and DRAIN.
REQ-021 In IDLE, adc_pd, adc_start and rx_en SHALL be 0, and cmd_stop SHALL be ignored.
REQ-022 IDLE SHALL go to PWRUP on cmd_start; num_samples SHALL be latched and overrun cleared in the same cycle.
REQ-023 In PWRUP, adc_pd SHALL be 1 and a timer SHALL count PWRUP_CYC cycles, then the FSM SHALL go to SETTLE.
REQ-024 In SETTLE, CAPTURE and DRAIN, adc_pd and adc_start SHALL be 1; rx_en SHALL be 1 in SETTLE and CAPTURE only.
REQ-025 In SETTLE, the first DISCARD smp_valid strobes SHALL be dropped and the FSM SHALL then go to CAPTURE; DISCARD=0 SHALL skip SETTLE.
REQ-026 In CAPTURE, each smp_valid SHALL push smp_data into the FIFO and increment a 16-bit sample counter.
REQ-027 A push at a full FIFO SHALL be accepted if a pop (m_valid&m_ready) occurs in the same cycle.
REQ-028 If the FIFO is full with no pop, the sample SHALL be dropped, overrun SHALL set, and the counter SHALL still increment.
REQ-029 When the counter reaches a nonzero latched num_samples, that sample SHALL carry a last tag and the FSM SHALL go to DRAIN.
REQ-030 With num_samples=0, the counter SHALL wrap at 0xFFFF and the FSM SHALL never exit CAPTURE by count.
REQ-031 cmd_stop in PWRUP, SETTLE or CAPTURE SHALL go to DRAIN; no last tag SHALL be generated.
REQ-032 DRAIN SHALL go to IDLE in the cycle after the FIFO becomes empty.
REQ-033 cmd_start outside IDLE SHALL be ignored; cmd_stop SHALL win if both pulse in the same cycle.
REQ-034 Latency from smp_valid into an empty FIFO to m_valid SHALL be 1 cycle.
REQ-035 m_data, m_last and m_valid SHALL stay stable while m_valid=1 and m_ready=0.
REQ-036 m_last SHALL be the stored last tag of the head entry.

Reset
REQ-037 On rst_n=0, the FSM SHALL be IDLE, the FIFO empty, and the timer and counter 0.
REQ-038 On rst_n=0, every output SHALL be 0: adc_pd, adc_start, rx_en, m_valid, m_last, busy, overrun and m_data.
REQ-039 Reset mid-session SHALL discard buffered samples with no m_valid pulse.

Structure
REQ-040 Package ads127l01_pkg SHALL hold SMP_W=24, CNT_W=16 and the FSM state enum.
REQ-041 The buffer SHALL be a sub-module, capture_fifo: synchronous, 25 bits wide (data + last), with full and empty flags.

Verification
REQ-042 num_samples=3, PWRUP_CYC=8, DISCARD=2, m_ready=1, 6 strobes -> adc_start rises 8 cycles after adc_pd; 4th-6th samples output; m_last on the 6th; IDLE afterward.
REQ-043 m_ready=0, FIFO_DEPTH=4, 5 strobes in CAPTURE -> 4 entries held; overrun=1; raising m_ready yields the 4 oldest samples in order.
REQ-044 num_samples=0, 70000 strobes -> no exit, no m_last; cmd_stop -> DRAIN, then IDLE.
REQ-045 cmd_start and cmd_stop in the same cycle in IDLE -> stays IDLE; busy=0.
REQ-046 rst_n low for 1 cycle in CAPTURE with 2 entries buffered -> all outputs 0 next cycle; FIFO empty.

Source files
------------

// File: rtl/ads127l01_pkg.sv
// ads127l01_pkg -- shared widths and FSM state type for the ADS127L01 capture
// controller.
//   SMP_W   : width of one ADC sample word
//   CNT_W   : width of the session sample counter / num_samples
//   state_t : capture controller FSM states
package ads127l01_pkg;

    localparam int SMP_W = 24;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        PWRUP,
        SETTLE,
        CAPTURE,
        DRAIN
    } state_t;

endpackage

// File: rtl/capture_fifo.sv
// capture_fifo -- synchronous single-clock FIFO with show-ahead head word.
// The head entry is presented combinationally from the storage array, so a
// word written into an empty FIFO is visible one cycle after the push.
// rd_data is forced to zero while the FIFO is empty so nothing stale leaks out
// after reset.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push       : write wr_data (accepted when not full, or full with a pop)
//   wr_data    : word to write
//   pop        : consumer takes the head word (ignored when empty)
//   rd_data    : head word, zero when empty
//   full/empty : occupancy flags
// DEPTH must be a power of two and at least 2.
module capture_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_CNT);
    assign pop_ok  = pop & ~empty;
    // When full, the slot being written is the one being read out this cycle.
    assign push_ok = push & (~full | pop_ok);
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

    // Storage has no reset so it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ads127l01_capture_ctrl.sv
// ads127l01_capture_ctrl -- session controller for an ADS127L01 ADC.
// Sequences power-up (adc_pd), conversion start (adc_start) and the serial
// receiver enable, drops the first DISCARD samples while the digital filter
// settles, then buffers samples into a small FIFO with a last-sample tag.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   cmd_start/cmd_stop: one-cycle session start / abort pulses (stop wins)
//   num_samples       : session length, 0 = continuous
//   smp_data/smp_valid: sample word and its one-cycle strobe
//   adc_pd, adc_start : ADC pins (adc_pd is the active-low power-down pin)
//   rx_en             : serial receiver enable
//   m_data/m_valid/m_ready/m_last : buffered sample stream
//   busy              : controller is not idle
//   overrun           : sticky, a sample was dropped on a full FIFO
module ads127l01_capture_ctrl
    import ads127l01_pkg::*;
#(
    parameter int PWRUP_CYC  = 1024,
    parameter int DISCARD    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [SMP_W-1:0] smp_data,
    input  logic             smp_valid,
    output logic             adc_pd,
    output logic             adc_start,
    output logic             rx_en,
    output logic [SMP_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             overrun
);

    localparam int TMR_W = $clog2(PWRUP_CYC + 1);
    localparam int DSC_W = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PWRUP_CYC - 1);
    localparam logic [DSC_W-1:0] DSC_LAST = DSC_W'((DISCARD > 0) ? DISCARD - 1 : 0);

    state_t           state_reg;
    state_t           state_next;
    logic [TMR_W-1:0] timer_reg;
    logic [DSC_W-1:0] disc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] num_reg;
    logic [CNT_W-1:0] cnt_inc;
    logic             overrun_reg;
    logic             adc_pd_reg;
    logic             adc_start_reg;
    logic             rx_en_reg;
    logic             busy_reg;

    logic             is_last;
    logic             cap_strobe;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             drop;
    logic [SMP_W:0]   fifo_rdata;

    assign cnt_inc    = cnt_reg + CNT_W'(1);
    assign is_last    = (num_reg != '0) && (cnt_inc == num_reg);
    // A stop pulse aborts immediately; a strobe in the same cycle is not kept.
    assign cap_strobe = (state_reg == CAPTURE) && smp_valid && !cmd_stop;
    assign fifo_pop   = m_ready & ~fifo_empty;
    assign drop       = cap_strobe & fifo_full & ~fifo_pop;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_start && !cmd_stop) begin
                    state_next = PWRUP;
                end
            end
            PWRUP: begin
                if (cmd_stop) begin
                    state_next = DRAIN;
                end else if (timer_reg == TMR_LAST) begin
                    state_next = (DISCARD == 0) ? CAPTURE : SETTLE;
                end
            end
            SETTLE: begin
                if (cmd_stop) begin
                    state_next = DRAIN;
                end else if (smp_valid && (disc_reg == DSC_LAST)) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (cmd_stop) begin
                    state_next = DRAIN;
                end else if (smp_valid && is_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Leave one cycle after the buffer has been seen empty.
                if (fifo_empty) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pin outputs are registered from the next state so they change together
    // with the state register and never glitch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            disc_reg      <= '0;
            cnt_reg       <= '0;
            num_reg       <= '0;
            overrun_reg   <= 1'b0;
            adc_pd_reg    <= 1'b0;
            adc_start_reg <= 1'b0;
            rx_en_reg     <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            adc_pd_reg    <= (state_next != IDLE);
            adc_start_reg <= (state_next == SETTLE) || (state_next == CAPTURE) ||
                             (state_next == DRAIN);
            rx_en_reg     <= (state_next == SETTLE) || (state_next == CAPTURE);
            busy_reg      <= (state_next != IDLE);

            if (state_reg == PWRUP) begin
                timer_reg <= timer_reg + TMR_W'(1);
            end else begin
                timer_reg <= '0;
            end

            if (state_reg != SETTLE) begin
                disc_reg <= '0;
            end else if (smp_valid) begin
                disc_reg <= disc_reg + DSC_W'(1);
            end

            if (state_reg == IDLE && state_next == PWRUP) begin
                num_reg     <= num_samples;
                cnt_reg     <= '0;
                overrun_reg <= 1'b0;
            end else begin
                // Dropped samples still count toward the session length.
                if (cap_strobe) begin
                    cnt_reg <= cnt_inc;
                end
                if (drop) begin
                    overrun_reg <= 1'b1;
                end
            end
        end
    end

    capture_fifo #(
        .WIDTH (SMP_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cap_strobe),
        .wr_data ({is_last, smp_data}),
        .pop     (m_ready),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_valid   = ~fifo_empty;
    assign m_data    = fifo_rdata[SMP_W-1:0];
    assign m_last    = fifo_rdata[SMP_W];
    assign adc_pd    = adc_pd_reg;
    assign adc_start = adc_start_reg;
    assign rx_en     = rx_en_reg;
    assign busy      = busy_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_ads127l01_capture_ctrl.sv
// tb_ads127l01_capture_ctrl -- directed bench with a session-level reference
// model (phase + queue) checked against the DUT on every cycle, plus literal
// expectations for the directed scenarios.
module tb_ads127l01_capture_ctrl;

    localparam int PWRUP_CYC  = 8;
    localparam int DISCARD    = 2;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_stop = 1'b0;
    logic [15:0] num_samples = '0;
    logic [23:0] smp_data = '0;
    logic        smp_valid = 1'b0;
    logic        m_ready = 1'b0;
    logic        adc_pd, adc_start, rx_en, m_valid, m_last, busy, overrun;
    logic [23:0] m_data;

    ads127l01_capture_ctrl #(
        .PWRUP_CYC  (PWRUP_CYC),
        .DISCARD    (DISCARD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_start   (cmd_start),
        .cmd_stop    (cmd_stop),
        .num_samples (num_samples),
        .smp_data    (smp_data),
        .smp_valid   (smp_valid),
        .adc_pd      (adc_pd),
        .adc_start   (adc_start),
        .rx_en       (rx_en),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int fail_prints = 0;
    bit started = 1'b0;
    bit quiet = 1'b0;
    int last_seen = 0;
    int pd_only = 0;

    typedef struct {
        logic [23:0] data;
        logic        last;
    } item_t;

    item_t got[$];

    // Reference model: session phase, counters and the expected buffer content.
    typedef enum int {P_IDLE, P_PWRUP, P_SETTLE, P_CAPTURE, P_DRAIN} phase_t;
    phase_t ph = P_IDLE;
    item_t  mq[$];
    int     tmr = 0, disc = 0, cnt = 0, nlat = 0;
    bit     ovr = 1'b0;

    always @(posedge clk) begin : model_step
        int sz;
        bit pop;
        bit lst;
        started = 1'b1;
        // Record DUT output handshakes (observation only).
        if (rst_n && m_valid === 1'b1 && m_ready) begin
            if (m_last === 1'b1) last_seen++;
            if (!quiet) begin
                got.push_back('{m_data, m_last});
                $display("[%0t] out #%0d data=%h last=%b", $time, got.size(), m_data, m_last);
            end
        end
        if (!rst_n) begin
            ph = P_IDLE; mq.delete(); tmr = 0; disc = 0; cnt = 0; nlat = 0; ovr = 1'b0;
        end else begin
            sz  = mq.size();
            pop = (sz > 0) && m_ready;
            if (pop) void'(mq.pop_front());
            case (ph)
                P_IDLE: if (cmd_start && !cmd_stop) begin
                    ph = P_PWRUP; tmr = 0; nlat = int'(num_samples); ovr = 1'b0; cnt = 0; disc = 0;
                end
                P_PWRUP: if (cmd_stop) ph = P_DRAIN;
                    else begin
                        tmr++;
                        if (tmr == PWRUP_CYC) ph = (DISCARD == 0) ? P_CAPTURE : P_SETTLE;
                    end
                P_SETTLE: if (cmd_stop) ph = P_DRAIN;
                    else if (smp_valid) begin
                        disc++;
                        if (disc == DISCARD) ph = P_CAPTURE;
                    end
                P_CAPTURE: if (cmd_stop) ph = P_DRAIN;
                    else if (smp_valid) begin
                        cnt = (cnt + 1) % 65536;
                        lst = (nlat != 0) && (cnt == nlat);
                        if (sz < FIFO_DEPTH || pop) mq.push_back('{smp_data, lst});
                        else ovr = 1'b1;
                        if (lst) ph = P_DRAIN;
                    end
                P_DRAIN: if (sz == 0) ph = P_IDLE;
                default: ph = P_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : compare
        logic        e_pd, e_st, e_rx, e_v, e_l;
        logic [23:0] e_d;
        if (started) begin
            e_pd = (ph != P_IDLE);
            e_st = (ph == P_SETTLE) || (ph == P_CAPTURE) || (ph == P_DRAIN);
            e_rx = (ph == P_SETTLE) || (ph == P_CAPTURE);
            e_v  = (mq.size() > 0);
            e_d  = e_v ? mq[0].data : 24'h0;
            e_l  = e_v ? mq[0].last : 1'b0;
            vectors++;
            if ({adc_pd, adc_start, rx_en, busy, overrun, m_valid, m_last, m_data} !==
                {e_pd, e_st, e_rx, e_pd, ovr, e_v, e_l, e_d}) begin
                miscompares++;
                if (fail_prints < 40) begin
                    fail_prints++;
                    $display("FAIL cycle_check @%0t: got pd=%b st=%b rx=%b busy=%b ovr=%b v=%b last=%b data=%h, want pd=%b st=%b rx=%b busy=%b ovr=%b v=%b last=%b data=%h",
                             $time, adc_pd, adc_start, rx_en, busy, overrun, m_valid, m_last, m_data,
                             e_pd, e_st, e_rx, e_pd, ovr, e_v, e_l, e_d);
                end
            end
        end
    end

    always @(negedge clk) if (adc_pd === 1'b1 && adc_start === 1'b0) pd_only++;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] want);
        vectors++;
        if (actual !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, actual, want);
        end
    endtask

    task automatic strobe(input logic [23:0] d);
        smp_data = d; smp_valid = 1'b1;
        @(negedge clk);
        smp_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_session(input logic [15:0] n);
        num_samples = n; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1;
        @(negedge clk);
        cmd_stop = 1'b0;
    endtask

    task automatic wait_settle(input string name);
        int k = 0;
        while (adc_start !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        check({name, " adc_start"}, 32'(adc_start), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
        check({name, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic enter_capture(input logic [15:0] n, input string name);
        start_session(n);
        wait_settle(name);
        strobe(24'hDEAD01);
        strobe(24'hDEAD02);
    endtask

    initial begin : stim
        logic [23:0] want_d;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset pd", 32'(adc_pd), 32'd0);
        check("reset m_valid", 32'(m_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Finite session: strobe 1 lands in power-up, 2-3 discarded, 4-6 kept.
        $display("[%0t] test1 finite session num_samples=3", $time);
        got.delete(); pd_only = 0; m_ready = 1'b1;
        start_session(16'd3);
        strobe(24'hA00001);
        wait_settle("t1");
        for (int i = 2; i <= 6; i++) strobe(24'hA00000 + 24'(i));
        wait_idle("t1");
        check("t1 pd_before_start", 32'(pd_only), 32'd8);
        check("t1 count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            want_d = 24'hA00004 + 24'(i);
            check($sformatf("t1 data%0d", i), 32'(got[i].data), 32'(want_d));
            check($sformatf("t1 last%0d", i), 32'(got[i].last), (i == 2) ? 32'd1 : 32'd0);
        end

        // Overrun: 5 strobes into a depth-4 FIFO with no consumer.
        $display("[%0t] test2 overrun", $time);
        got.delete(); m_ready = 1'b0;
        enter_capture(16'd10, "t2");
        for (int i = 1; i <= 5; i++) strobe(24'hB00000 + 24'(i));
        check("t2 overrun", 32'(overrun), 32'd1);
        check("t2 m_valid", 32'(m_valid), 32'd1);
        pulse_stop();
        m_ready = 1'b1;
        wait_idle("t2");
        check("t2 count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            want_d = 24'hB00001 + 24'(i);
            check($sformatf("t2 data%0d", i), 32'(got[i].data), 32'(want_d));
            check($sformatf("t2 last%0d", i), 32'(got[i].last), 32'd0);
        end

        // Push into a full FIFO with a simultaneous pop is accepted.
        $display("[%0t] test3 full push with pop", $time);
        got.delete(); m_ready = 1'b0;
        enter_capture(16'd0, "t3");
        for (int i = 1; i <= 4; i++) strobe(24'hC00000 + 24'(i));
        check("t3 overrun_before", 32'(overrun), 32'd0);
        smp_data = 24'hC00005; smp_valid = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        smp_valid = 1'b0;
        check("t3 overrun_after", 32'(overrun), 32'd0);
        repeat (6) @(negedge clk);
        pulse_stop();
        wait_idle("t3");
        check("t3 count", 32'(got.size()), 32'd5);
        check("t3 data4", 32'(got[4].data), 32'hC00005);

        // Continuous session past the 16-bit counter wrap, then abort.
        $display("[%0t] test4 continuous 70000 strobes", $time);
        quiet = 1'b1; last_seen = 0; m_ready = 1'b1;
        enter_capture(16'd0, "t4");
        smp_valid = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            smp_data = 24'(i);
            @(negedge clk);
        end
        smp_valid = 1'b0;
        check("t4 busy", 32'(busy), 32'd1);
        check("t4 rx_en", 32'(rx_en), 32'd1);
        check("t4 no_last", 32'(last_seen), 32'd0);
        pulse_stop();
        check("t4 drain rx_en", 32'(rx_en), 32'd0);
        check("t4 drain busy", 32'(busy), 32'd1);
        wait_idle("t4");
        quiet = 1'b0;

        // Start and stop together in IDLE: nothing happens.
        $display("[%0t] test5 start+stop in idle", $time);
        cmd_start = 1'b1; cmd_stop = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0; cmd_stop = 1'b0;
        check("t5 busy", 32'(busy), 32'd0);
        check("t5 pd", 32'(adc_pd), 32'd0);

        // Reset in CAPTURE with two entries buffered.
        $display("[%0t] test6 reset mid-session", $time);
        m_ready = 1'b0;
        enter_capture(16'd0, "t6");
        strobe(24'hD00001);
        strobe(24'hD00002);
        check("t6 m_valid_before", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6 outputs zero",
              32'({adc_pd, adc_start, rx_en, m_valid, m_last, busy, overrun, m_data}), 32'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t6 no_valid%0d", i), 32'(m_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "timeout");
    end

endmodule
